// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative RV32M multiplier.
package mul_pkg;

   localparam int XLEN  = 32;
   localparam int ITER  = 32;
   localparam int CNT_W = $clog2(ITER);

   // RV32M multiply encodings of funct3. Encodings with bit 2 set are the
   // divide ops; the multiplier accepts them but returns zero.
   typedef enum logic [2:0] {
      MUL_LO  = 3'b000,
      MULH_SS = 3'b001,
      MULH_SU = 3'b010,
      MULH_UU = 3'b011
   } mul_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Absolute value of an operand that may be signed. The most negative value
   // maps onto itself, which is the correct unsigned magnitude 2^31.
   function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x,
                                                 input logic            is_signed);
      return (is_signed && x[XLEN-1]) ? (~x + XLEN'(1)) : x;
   endfunction

   // Operand a is signed for MULH and MULHSU.
   function automatic logic a_is_signed(input logic [2:0] f3);
      return (f3 == MULH_SS) || (f3 == MULH_SU);
   endfunction

   // Operand b is signed for MULH only.
   function automatic logic b_is_signed(input logic [2:0] f3);
      return (f3 == MULH_SS);
   endfunction

endpackage

// File: rtl/mul_unit_if.sv
// Execute-stage handshake between the core and the multiplier.
interface mul_unit_if;
   import mul_pkg::*;

   logic            start;
   logic [2:0]      funct3;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   // Core side: issues requests and consumes the result.
   modport master (
      output start, funct3, a, b,
      input  busy, done, result
   );

   // Multiplier side.
   modport slave (
      input  start, funct3, a, b,
      output busy, done, result
   );

endinterface

// File: rtl/mul_unit_rca.sv
// 32-bit ripple-carry adder used for the shift-add step of the multiplier.
module mul_unit_rca
   import mul_pkg::*;
(
   input  logic [XLEN-1:0] i_a,
   input  logic [XLEN-1:0] i_b,
   input  logic            i_cin,
   output logic [XLEN-1:0] o_sum,
   output logic            o_cout
);

   logic [XLEN:0] w_carry;

   assign w_carry[0] = i_cin;

   // One full adder per bit; the carry ripples from bit 0 upward.
   for (genvar i = 0; i < XLEN; i++) begin : g_bit
      assign o_sum[i]     = i_a[i] ^ i_b[i] ^ w_carry[i];
      assign w_carry[i+1] = (i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] ^ i_b[i]));
   end

   assign o_cout = w_carry[XLEN];

endmodule

// File: rtl/mul_unit.sv
// Iterative 32x32 multiplier for MUL/MULH/MULHSU/MULHU. Operands are reduced to
// magnitudes, multiplied by 32 shift-add steps, the sign is restored in FIX,
// and the selected half is presented with a one-cycle done pulse.
module mul_unit
   import mul_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   mul_unit_if.slave  io_bus
);

   state_t              r_state;
   state_t              w_state_nxt;
   logic                w_busy;
   logic                w_done;

   logic [CNT_W-1:0]    r_cnt;
   logic [2:0]          r_funct3;
   logic [XLEN-1:0]     r_mag_a;
   logic                r_neg;
   logic [2*XLEN-1:0]   r_p;
   logic [XLEN-1:0]     r_result;

   logic                w_a_signed;
   logic                w_b_signed;
   logic [XLEN-1:0]     w_mag_a;
   logic [XLEN-1:0]     w_mag_b;
   logic                w_neg;
   logic [XLEN-1:0]     w_add_b;
   logic [XLEN-1:0]     w_sum;
   logic                w_cout;
   logic [2*XLEN-1:0]   w_p_step;
   logic [2*XLEN-1:0]   w_p_fixed;
   logic [XLEN-1:0]     w_result_sel;
   logic                w_last_iter;

   // ------------------------------------------------------------------
   // Operand conditioning at acceptance time
   // ------------------------------------------------------------------
   assign w_a_signed = a_is_signed(io_bus.funct3);
   assign w_b_signed = b_is_signed(io_bus.funct3);
   assign w_mag_a    = magnitude(io_bus.a, w_a_signed);
   assign w_mag_b    = magnitude(io_bus.b, w_b_signed);
   assign w_neg      = (w_a_signed & io_bus.a[XLEN-1]) ^ (w_b_signed & io_bus.b[XLEN-1]);

   // ------------------------------------------------------------------
   // Shift-add datapath: add |a| to the upper half when the multiplier
   // LSB is set, then shift the whole product right with the carry in.
   // ------------------------------------------------------------------
   assign w_add_b = r_p[0] ? r_mag_a : '0;

   mul_unit_rca u_rca (
      .i_a    (r_p[2*XLEN-1:XLEN]),
      .i_b    (w_add_b),
      .i_cin  (1'b0),
      .o_sum  (w_sum),
      .o_cout (w_cout)
   );

   assign w_p_step = {w_cout, w_sum, r_p[XLEN-1:1]};

   // Sign restoration; negating zero yields zero, so no special case.
   assign w_p_fixed = r_neg ? (~r_p + (2*XLEN)'(1)) : r_p;

   assign w_last_iter = (r_cnt == CNT_W'(ITER - 1));

   // Select the architecturally visible half; divide encodings return zero.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      w_result_sel = '0;
      if (!r_funct3[2]) begin
         if (r_funct3 == MUL_LO) w_result_sel = w_p_fixed[XLEN-1:0];
         else                    w_result_sel = w_p_fixed[2*XLEN-1:XLEN];
      end
   end

   // ------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------

   // State register.
   always_ff @(posedge i_clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of block ordering.
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state and handshake outputs.
   always_comb begin
      w_state_nxt = r_state;
      w_busy      = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         IDLE: begin
            if (io_bus.start) w_state_nxt = CALC;
         end
         CALC: begin
            w_busy = 1'b1;
            if (w_last_iter) w_state_nxt = FIX;
         end
         FIX: begin
            w_busy      = 1'b1;
            w_state_nxt = DONE;
         end
         DONE: begin
            w_busy      = 1'b1;
            w_done      = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Operand capture, iteration, sign fix-up and result latch.
   always_ff @(posedge i_clk) begin
      // NOTE: the product and result registers are reset explicitly so an
      // aborted operation leaves no stale value on the result port.
      if (i_rst) begin
         r_cnt    <= '0;
         r_funct3 <= '0;
         r_mag_a  <= '0;
         r_neg    <= 1'b0;
         r_p      <= '0;
         r_result <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (io_bus.start) begin
                  r_funct3 <= io_bus.funct3;
                  r_mag_a  <= w_mag_a;
                  r_neg    <= w_neg;
                  r_p      <= {{XLEN{1'b0}}, w_mag_b};
                  r_cnt    <= '0;
               end
            end
            CALC: begin
               r_p   <= w_p_step;
               r_cnt <= r_cnt + CNT_W'(1);
            end
            FIX: begin
               // The result is latched here so it is already stable in the
               // cycle that done is raised.
               r_p      <= w_p_fixed;
               r_result <= w_result_sel;
            end
            default: begin
            end
         endcase
      end
   end

   assign io_bus.busy   = w_busy;
   assign io_bus.done   = w_done;
   assign io_bus.result = r_result;

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: a cycle-count reference model checked on
// every cycle, plus directed operations with hand-computed results.
module tb_mul_unit;
   import mul_pkg::*;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   mul_unit_if bus ();

   mul_unit dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .io_bus (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference product from plain 64-bit arithmetic on extended operands.
   function automatic logic [31:0] ref_mul(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [63:0] ea, eb, prod;
      if (f3[2]) return 32'h0;
      ea   = (f3 == 3'b001 || f3 == 3'b010) ? {{32{a[31]}}, a} : {32'h0, a};
      eb   = (f3 == 3'b001) ? {{32{b[31]}}, b} : {32'h0, b};
      prod = ea * eb;
      return (f3 == 3'b000) ? prod[31:0] : prod[63:32];
   endfunction

   // Timing model: m_cnt is the cycle index since the start-sample edge
   // (0 = idle); done in cycle 34, busy in cycles 1..34.
   int          m_cnt   = 0;
   bit          m_valid = 1'b0;
   logic [31:0] m_pending;
   logic [31:0] m_result;

   always @(posedge clk) begin
      if (rst) begin
         m_cnt    <= 0;
         m_result <= 32'h0;
         m_valid  <= 1'b1;
      end else if (m_cnt == 0) begin
         if (bus.start === 1'b1) begin
            m_cnt     <= 1;
            m_pending <= ref_mul(bus.funct3, bus.a, bus.b);
         end
      end else if (m_cnt == 34) begin
         m_cnt <= 0;
      end else begin
         if (m_cnt == 33) m_result <= m_pending;
         m_cnt <= m_cnt + 1;
      end
   end

   // Compare process: outputs checked against the model every cycle.
   always @(negedge clk) begin
      if (m_valid) begin
         check("busy",   32'(bus.busy), 32'(m_cnt != 0));
         check("done",   32'(bus.done), 32'(m_cnt == 34));
         check("result", bus.result,    m_result);
      end
   end

   task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      @(posedge clk);
      #1;
      bus.start  = 1'b1;
      bus.funct3 = f3;
      bus.a      = a;
      bus.b      = b;
      @(posedge clk);
      #1;
      bus.start  = 1'b0;
      bus.a      = $urandom;
      bus.b      = $urandom;
      bus.funct3 = 3'($urandom);
   endtask

   // Counts negedges until done; lat = -1 if the bound expires.
   task automatic wait_done(output int lat);
      bit seen;
      seen = 1'b0;
      lat  = -1;
      for (int i = 1; i <= 100 && !seen; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            seen = 1'b1;
            lat  = i;
         end
      end
   endtask

   task automatic run(input string name, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp);
      int lat;
      issue(f3, a, b);
      wait_done(lat);
      check({name, " latency"}, 32'(lat), 32'd34);
      check({name, " result"}, bus.result, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, lat2, seen_done;

      rst        = 1'b1;
      bus.start  = 1'b0;
      bus.funct3 = 3'b000;
      bus.a      = 32'h0;
      bus.b      = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset busy",   32'(bus.busy), 32'h0);
      check("reset done",   32'(bus.done), 32'h0);
      check("reset result", bus.result,    32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Basic and signedness vectors.
      run("MUL 7*6",          3'b000, 32'd7,        32'd6,        32'h0000002A);
      run("MULHU max*max",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
      run("MUL max*max",      3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
      run("MULH -8*3",        3'b001, 32'hFFFFFFF8, 32'd3,        32'hFFFFFFFF);
      run("MULH min*min",     3'b001, 32'h80000000, 32'h80000000, 32'h40000000);
      run("MULHSU -1*umax",   3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
      run("MUL -1*umax",      3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
      run("MULH 0*-5",        3'b001, 32'h00000000, 32'hFFFFFFFB, 32'h00000000);
      run("div encoding",     3'b100, 32'd100,      32'd7,        32'h00000000);

      // Start re-asserted during CALC with other operands is ignored.
      issue(3'b000, 32'd7, 32'd6);
      repeat (4) @(posedge clk);
      #1;
      bus.start  = 1'b1;
      bus.funct3 = 3'b000;
      bus.a      = 32'd100;
      bus.b      = 32'd100;
      @(posedge clk);
      #1;
      bus.start  = 1'b0;
      wait_done(lat);
      check("ignore latency", 32'(lat), 32'd29);
      check("ignore result",  bus.result, 32'h0000002A);

      // Reset in cycle 10 aborts: no done, result cleared.
      issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF);
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      seen_done = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done === 1'b1) seen_done++;
      end
      check("abort no done", 32'(seen_done), 32'h0);
      check("abort result",  bus.result,     32'h0);
      run("post-reset MUL", 3'b000, 32'd12345, 32'd1000, 32'h00BC5EA8);

      // Back-to-back: second start sampled in cycle 35, done in cycle 69.
      issue(3'b001, 32'hFFFFFFF8, 32'd3);
      wait_done(lat);
      check("b2b first result", bus.result, 32'hFFFFFFFF);
      issue(3'b011, 32'h12345678, 32'h00000010);
      wait_done(lat2);
      check("b2b total cycles", 32'(lat + 1 + lat2), 32'd69);
      check("b2b second result", bus.result, 32'h00000001);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
